// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg: shared defaults and operation-select encoding for the program sequencer.
package program_sequencer_pkg;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_BRANCH,
        OP_CALL,
        OP_RET
    } op_e;

endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses with pointer counting 0..DEPTH.
// Ports: clk, reset (async, active-low), push, pop, data_in, data_out (top entry),
//        empty (ptr==0), full (ptr==DEPTH).
// Push while full and pop while empty are ignored; the caller reports those errors.
module ret_stack
    import program_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH = DEF_STACK_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [PW-1:0]    top;
    logic             do_push;
    logic             do_pop;

    assign empty    = ptr_q == '0;
    assign full     = ptr_q == PW'(DEPTH);
    assign top      = ptr_q - 1'b1;
    assign data_out = mem_q[top[AW-1:0]];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        ptr_d = ptr_q;
        ptr_d = do_push ? ptr_q + 1'b1 : do_pop ? ptr_q - 1'b1 : ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // Contents are not reset: with ptr at 0 stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[ptr_q[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: program counter with increment, jump, call/return stack and sticky stack error.
// Ports: clk, reset (async, active-low), enable/load/call/ret requests,
//        [branch_rel when PC_BRANCH_REL_EN is defined], counter_in (target/offset),
//        counter_out (registered address), stack_empty, stack_full, stack_err (sticky).
// Priority: ret > call > branch_rel > load > enable > hold.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic                  call,
    input  logic                  ret,
`ifdef PC_BRANCH_REL_EN
    input  logic                  branch_rel,
`endif
    input  logic [ADDR_WIDTH-1:0] counter_in,
    output logic [ADDR_WIDTH-1:0] counter_out,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  stack_err
);

    op_e                   op;
    logic                  br;
    logic                  push;
    logic                  pop;
    logic                  err_q;
    logic                  err_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] ret_addr;

`ifdef PC_BRANCH_REL_EN
    assign br = branch_rel;
`else
    assign br = 1'b0;
`endif

    // A failed call/ret holds the PC and only raises the error flag.
    always_comb begin
        op    = ret ? OP_RET : call ? OP_CALL : br ? OP_BRANCH : load ? OP_LOAD : enable ? OP_INC : OP_HOLD;
        push  = (op == OP_CALL) && !stack_full;
        pop   = (op == OP_RET) && !stack_empty;
        err_d = err_q | ((op == OP_CALL) && stack_full) | ((op == OP_RET) && stack_empty);
        pc_d  = pop                ? ret_addr :
                push               ? counter_in :
                (op == OP_BRANCH)  ? pc_q + counter_in :
                (op == OP_LOAD)    ? counter_in :
                (op == OP_INC)     ? pc_q + 1'b1 :
                                     pc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    ret_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (pc_q + 1'b1),
        .data_out (ret_addr),
        .empty    (stack_empty),
        .full     (stack_full)
    );

    assign counter_out = pc_q;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed and random checks of program_sequencer against a queue-based model.
module tb_program_sequencer;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic       load   = 1'b0;
    logic       call   = 1'b0;
    logic       ret    = 1'b0;
    logic       br     = 1'b0;
    logic [7:0] cin    = 8'h00;
    logic [7:0] counter_out;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    int n_cmp = 0;
    int n_bad = 0;

    int m_pc;
    int m_stk[$];
    bit m_err;

`ifdef PC_BRANCH_REL_EN
    localparam bit HAS_BR = 1'b1;
`else
    localparam bit HAS_BR = 1'b0;
`endif

    always #5 clk = ~clk;

    program_sequencer #(
        .ADDR_WIDTH  (8),
        .STACK_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .call        (call),
        .ret         (ret),
`ifdef PC_BRANCH_REL_EN
        .branch_rel  (br),
`endif
        .counter_in  (cin),
        .counter_out (counter_out),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 32'(counter_out), 32'(m_pc));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
        chk({tag, ".full"}, 32'(stack_full), 32'(m_stk.size() == 4));
        chk({tag, ".err"}, 32'(stack_err), 32'(m_err));
    endtask

    task automatic model_step(input bit e, input bit l, input bit c, input bit r, input bit b, input int d);
        if (r) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (c) begin
            if (m_stk.size() == 4) m_err = 1'b1;
            else begin
                m_stk.push_back((m_pc + 1) % 256);
                m_pc = d;
            end
        end else if (b && HAS_BR) m_pc = (m_pc + d) % 256;
        else if (l) m_pc = d;
        else if (e) m_pc = (m_pc + 1) % 256;
    endtask

    task automatic cyc(input bit e, input bit l, input bit c, input bit r, input bit b, input logic [7:0] d);
        enable = e; load = l; call = c; ret = r; br = b; cin = d;
        @(posedge clk);
        #1;
        model_step(e, l, c, r, b, int'(d));
        check_all("cyc");
    endtask

    // Asserted between edges so the async clear is visible before any clock.
    task automatic hard_reset();
        reset = 1'b0;
        #1;
        m_pc = 0;
        m_stk.delete();
        m_err = 1'b0;
        check_all("rst_async");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2;
        hard_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 8'h00);
        chk("inc4", 32'(counter_out), 32'h04);
        @(negedge clk);
        enable = 1'b1;
        #2;
        hard_reset();
        chk("rst_mid", 32'(counter_out), 32'h00);

        cyc(0, 1, 0, 0, 0, 8'hFE);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 8'h00);
        chk("wrap", 32'(counter_out), 32'h01);

        cyc(0, 1, 0, 0, 0, 8'h10);
        cyc(0, 0, 1, 0, 0, 8'h40);
        cyc(0, 0, 1, 0, 0, 8'h80);
        cyc(0, 0, 0, 1, 0, 8'h00);
        chk("ret1", 32'(counter_out), 32'h41);
        cyc(0, 0, 0, 1, 0, 8'h00);
        chk("ret2", 32'(counter_out), 32'h11);
        chk("nest_err", 32'(stack_err), 32'h0);

        hard_reset();
        for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 0, 0, 8'(i * 16));
        chk("ovf_pc", 32'(counter_out), 32'h40);
        chk("ovf_err", 32'(stack_err), 32'h1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 8'h00);
        chk("unf_pc", 32'(counter_out), 32'h01);
        chk("unf_err", 32'(stack_err), 32'h1);

        hard_reset();
        cyc(0, 1, 0, 0, 0, 8'h21);
        cyc(0, 0, 1, 0, 0, 8'h60);
        cyc(1, 1, 1, 1, 0, 8'h99);
        chk("all_pc", 32'(counter_out), 32'h22);
        chk("all_err", 32'(stack_err), 32'h0);

`ifdef PC_BRANCH_REL_EN
        cyc(0, 1, 0, 0, 0, 8'h05);
        cyc(0, 0, 0, 0, 1, 8'hFD);
        chk("br_neg", 32'(counter_out), 32'h02);
        cyc(0, 1, 0, 0, 0, 8'hFE);
        cyc(0, 0, 0, 0, 1, 8'h04);
        chk("br_wrap", 32'(counter_out), 32'h02);
        cyc(0, 1, 0, 0, 1, 8'h10);
        chk("br_load", 32'(counter_out), 32'h12);
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) hard_reset();
            else cyc($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 6) == 0, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of the program address.
REQ-002 Parameter STACK_DEPTH, default 4, number of return-address entries; SHALL be >= 2.
REQ-003 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 Port enable  input  1  increment request.
REQ-006 Port load  input  1  absolute jump request.
REQ-007 Port call  input  1  subroutine call request.
REQ-008 Port ret  input  1  subroutine return request.
REQ-009 Port counter_in  input  ADDR_WIDTH  jump/call target, or branch offset.
REQ-010 Port counter_out  output  ADDR_WIDTH  current program address, registered.
REQ-011 Port stack_empty  output  1  no return addresses held.
REQ-012 Port stack_full  output  1  STACK_DEPTH return addresses held.
REQ-013 Port stack_err  output  1  sticky flag: overflow or underflow occurred.

Function
REQ-014 Per-cycle operation priority SHALL be ret > call > branch_rel (when compiled in) > load > enable > hold.
REQ-015 enable SHALL set counter_out to counter_out+1 at the next edge; from all-ones it SHALL wrap to 0.
REQ-016 load SHALL set counter_out to counter_in at the next edge; no increment in the same cycle.
REQ-017 call with stack not full SHALL push counter_out+1 (mod 2^ADDR_WIDTH) and set counter_out to counter_in in the same edge.
REQ-018 call with stack full SHALL leave counter_out and the stack unchanged and set stack_err.
REQ-019 ret with stack not empty SHALL pop the top entry into counter_out at the next edge.
REQ-020 ret with stack empty SHALL leave counter_out unchanged and set stack_err.
REQ-021 Simultaneous call and ret SHALL execute ret only; call is dropped without error.
REQ-022 Stack pointer SHALL count 0..STACK_DEPTH; stack_empty = (ptr==0), stack_full = (ptr==STACK_DEPTH), both combinational from registered ptr.
REQ-023 Operation latency SHALL be exactly one clock; counter_out reflects the request after the sampling edge.
REQ-024 stack_err SHALL remain set until reset; no other operation clears it.

Reset
REQ-025 Reset asserted SHALL immediately force counter_out=0, stack pointer=0, stack_err=0, without waiting for clk.
REQ-026 Reset mid-call/ret SHALL discard the operation; stack contents need not be cleared, but SHALL be unreachable (ptr=0).
REQ-027 First operation after reset deassertion SHALL be taken on the first rising edge at which reset is high.

Configuration
REQ-028 Macro PC_BRANCH_REL_EN defined: adds input branch_rel (1 bit); when selected, counter_out <= counter_out + counter_in, counter_in treated as two's-complement, result modulo 2^ADDR_WIDTH.
REQ-029 Macro PC_BRANCH_REL_EN undefined: branch_rel port absent; priority reduces to ret > call > load > enable > hold.

Structure
REQ-030 Shared package program_sequencer_pkg SHALL hold default ADDR_WIDTH and STACK_DEPTH constants and the operation-select encoding (OP_HOLD, OP_INC, OP_LOAD, OP_BRANCH, OP_CALL, OP_RET).
REQ-031 The LIFO SHALL be a sub-module ret_stack (push, pop, data_in, data_out, empty, full, async active-low reset); program_sequencer owns priority, error flag and counter register.

Verification (ADDR_WIDTH=8, STACK_DEPTH=4)
REQ-032 Reset low, then high with enable=1 for 4 edges -> counter_out 0x00,0x01..0x04; with reset low mid-count -> 0x00 immediately, before next edge.
REQ-033 load=1, counter_in=0xFE, then enable for 3 edges -> 0xFE, 0xFF, 0x00 (wrap), 0x01.
REQ-034 At 0x10 call to 0x40, at 0x40 call to 0x80, ret, ret -> 0x40, 0x80, 0x41, 0x11; stack_empty back to 1, stack_err 0.
REQ-035 Five calls from empty -> stack_full after 4th; 5th leaves counter_out at 4th target and sets stack_err; then 5 rets -> 4 pops, 5th holds address, stack_err stays 1.
REQ-036 call=1, ret=1, load=1, enable=1 together with one entry 0x22 on stack -> counter_out 0x22, stack_empty 1, stack_err 0.
REQ-037 With PC_BRANCH_REL_EN, at 0x05 branch_rel=1, counter_in=0xFD -> 0x02; at 0xFE counter_in=0x04 -> 0x02; branch_rel and load together -> branch wins.
